// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared single-cycle registered ALU.
// Latency: accept -> rsp_valid 3 cycles (normal) or 1 cycle (rejected op).
// Backpressure: one op in flight; req_ready stays 00 until the response is taken.
module alu_req_arbiter (
    input  logic        CLk,
    input  logic        Reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [7:0]  req_op,
    input  logic [1:0]  req_cin,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_cin,
    input  logic [15:0] alu_result,
    input  logic        alu_cout,
    input  logic        alu_zflag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_cout,
    output logic        rsp_zflag,
    output logic        rsp_err,
    output logic [15:0] ops_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0] state;
    logic       ptr;
    logic       winner;
    logic [1:0] grant;
    logic       accept;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic [3:0] sel_op;
    logic       sel_cin;
    logic       op_err;

    // ptr holds the last-served requester; a tie goes to the other one.
    always_comb begin
        winner = 1'b0;
        case (req_valid)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~ptr;
            default: winner = 1'b0;
        endcase
        grant = 2'b00;
        if (state == ST_IDLE && !Reset && req_valid != 2'b00)
            grant = winner ? 2'b10 : 2'b01;
    end

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign sel_a     = winner ? req_a[15:8]  : req_a[7:0];
    assign sel_b     = winner ? req_b[15:8]  : req_b[7:0];
    assign sel_op    = winner ? req_op[7:4]  : req_op[3:0];
    assign sel_cin   = winner ? req_cin[1]   : req_cin[0];
    assign op_err    = (sel_op > 4'd5) || (sel_op == 4'd3 && sel_b == 8'd0);
    assign rsp_valid = (state == ST_RESP);

    always_ff @(posedge CLk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            ptr        <= 1'b1;
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            alu_op     <= 4'd0;
            alu_cin    <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 16'd0;
            rsp_cout   <= 1'b0;
            rsp_zflag  <= 1'b0;
            rsp_err    <= 1'b0;
            ops_done   <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ptr    <= winner;
                        rsp_id <= winner;
                        if (op_err) begin
                            // Rejected ops bypass the ALU and leave its operands untouched.
                            rsp_err    <= 1'b1;
                            rsp_result <= 16'd0;
                            rsp_cout   <= 1'b0;
                            rsp_zflag  <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            alu_a   <= sel_a;
                            alu_b   <= sel_b;
                            alu_op  <= sel_op;
                            alu_cin <= sel_cin;
                            state   <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: state <= ST_CAPT;
                ST_CAPT: begin
                    rsp_result <= alu_result;
                    rsp_zflag  <= alu_zflag;
                    rsp_cout   <= (alu_op == 4'd0) ? alu_cout : 1'b0;
                    rsp_err    <= 1'b0;
                    state      <= ST_RESP;
                end
                default: begin
                    if (rsp_ready) begin
                        ops_done <= ops_done + 16'd1;
                        state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench: registered ALU model plus a queue of expected responses.
module tb_alu_req_arbiter;

    logic        CLk = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [15:0] req_a = 16'd0;
    logic [15:0] req_b = 16'd0;
    logic [7:0]  req_op = 8'd0;
    logic [1:0]  req_cin = 2'b00;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic        alu_cin;
    logic [15:0] alu_result = 16'd0;
    logic        alu_cout = 1'b0;
    logic        alu_zflag = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_cout;
    logic        rsp_zflag;
    logic        rsp_err;
    logic [15:0] ops_done;

    typedef struct packed {
        logic        id;
        logic [15:0] res;
        logic        cout;
        logic        z;
        logic        err;
    } rsp_t;

    rsp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_ops = 16'd0;

    alu_req_arbiter dut (
        .CLk(CLk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_zflag(alu_zflag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_zflag(rsp_zflag),
        .rsp_err(rsp_err), .ops_done(ops_done)
    );

    always #5 CLk = ~CLk;

    // Reference ALU: returns {zflag, cout, result}.
    function automatic logic [17:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op, input logic cin);
        logic [8:0]  s9;
        logic [15:0] r;
        logic        c;
        s9 = 9'd0;
        r  = 16'd0;
        c  = 1'b0;
        case (op)
            4'd0: begin s9 = {1'b0, a} + {1'b0, b} + {8'd0, cin}; r = {7'd0, s9}; c = s9[8]; end
            4'd1: begin s9 = {1'b0, a} - {1'b0, b}; r = {8'd0, s9[7:0]}; c = s9[8]; end
            4'd2: r = {8'd0, a & b};
            4'd3: r = (b != 8'd0) ? {8'd0, a / b} : 16'd0;
            4'd4: begin r = {8'd0, a | b}; c = 1'b1; end
            4'd5: begin r = {8'd0, a} * {8'd0, b}; c = |r[15:8]; end
            default: r = 16'd0;
        endcase
        return {(r == 16'd0), c, r};
    endfunction

    function automatic rsp_t exp_of(input logic id, input logic [7:0] a, input logic [7:0] b,
                                    input logic [3:0] op, input logic cin);
        rsp_t        e;
        logic [17:0] r;
        if (op > 4'd5 || (op == 4'd3 && b == 8'd0)) begin
            e = '{id: id, res: 16'd0, cout: 1'b0, z: 1'b1, err: 1'b1};
        end else begin
            r = alu_f(a, b, op, cin);
            e = '{id: id, res: r[15:0], cout: (op == 4'd0) ? r[16] : 1'b0, z: r[17], err: 1'b0};
        end
        return e;
    endfunction

    always @(posedge CLk)
        {alu_zflag, alu_cout, alu_result} <= alu_f(alu_a, alu_b, alu_op, alu_cin);

    task automatic set_lane(input int id, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] op, input logic cin);
        req_a[8*id +: 8]  = a;
        req_b[8*id +: 8]  = b;
        req_op[4*id +: 4] = op;
        req_cin[id]       = cin;
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (2) @(posedge CLk);
        #1 Reset = 1'b0;
        exp_ops = 16'd0;
        sb.delete();
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLk);
            if (req_ready != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called one step after the accepting edge; lat counts cycles from accept.
    task automatic wait_rsp(output int lat, output int busy);
        lat  = -1;
        busy = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLk);
            if (req_ready != 2'b00) busy++;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        req_valid = 2'b11;
        @(posedge CLk);
        @(negedge CLk);
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_zflag, rsp_err} !== 21'd0) begin
            errors++;
            $display("FAIL reset_rsp got v=%b id=%b res=%h c=%b z=%b e=%b want all 0",
                     rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_zflag, rsp_err);
        end
        checks++;
        if ({alu_a, alu_b, alu_op, alu_cin} !== 21'd0) begin
            errors++;
            $display("FAIL reset_alu got a=%h b=%h op=%h cin=%b want all 0", alu_a, alu_b, alu_op, alu_cin);
        end
        checks++;
        if (ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops_done got=%h want=0000", ops_done); end
        do_reset();
    endtask

    task automatic run_one(input string name, input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input logic cin, input int want_lat);
        bit          ok;
        int          lat;
        int          busy;
        rsp_t        e;
        rsp_t        got;
        logic [20:0] alu_before;
        set_lane(id, a, b, op, cin);
        req_valid[id] = 1'b1;
        sb.push_back(exp_of(id[0], a, b, op, cin));
        wait_grant(ok);
        checks++;
        if (!ok || req_ready !== (2'b01 << id)) begin
            errors++;
            $display("FAIL %s_grant got=%b want=%b", name, req_ready, 2'b01 << id);
            req_valid = 2'b00;
            void'(sb.pop_back());
            return;
        end
        alu_before = {alu_a, alu_b, alu_op, alu_cin};
        @(posedge CLk);
        #1 req_valid = 2'b00;
        wait_rsp(lat, busy);
        checks++;
        if (lat != want_lat) begin
            errors++;
            $display("FAIL %s_latency got=%0d want=%0d", name, lat, want_lat);
            if (lat < 0) begin void'(sb.pop_front()); return; end
        end
        e   = sb.pop_front();
        got = '{id: rsp_id, res: rsp_result, cout: rsp_cout, z: rsp_zflag, err: rsp_err};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s_rsp got id=%b res=%h c=%b z=%b e=%b want id=%b res=%h c=%b z=%b e=%b",
                     name, got.id, got.res, got.cout, got.z, got.err, e.id, e.res, e.cout, e.z, e.err);
        end
        if (e.err) begin
            checks++;
            if ({alu_a, alu_b, alu_op, alu_cin} !== alu_before) begin
                errors++;
                $display("FAIL %s_alu_hold got=%h want=%h", name, {alu_a, alu_b, alu_op, alu_cin}, alu_before);
            end
        end
        @(posedge CLk);
        exp_ops = exp_ops + 16'd1;
        #1;
        checks++;
        if (ops_done !== exp_ops || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_done got ops=%h v=%b want ops=%h v=0", name, ops_done, rsp_valid, exp_ops);
        end
    endtask

    task automatic test_add();
        run_one("add", 0, 8'hFF, 8'h01, 4'd0, 1'b1, 3);
    endtask

    task automatic test_ops();
        run_one("sub_borrow", 1, 8'd3, 8'd5, 4'd1, 1'b0, 3);
        run_one("and", 0, 8'hF0, 8'h3C, 4'd2, 1'b0, 3);
        run_one("div", 1, 8'd100, 8'd7, 4'd3, 1'b0, 3);
        run_one("or", 0, 8'h0F, 8'hF0, 4'd4, 1'b0, 3);
        run_one("mul", 1, 8'd20, 8'd13, 4'd5, 1'b0, 3);
        run_one("add_zero_low", 0, 8'h80, 8'h80, 4'd0, 1'b0, 3);
    endtask

    task automatic test_error();
        run_one("div_zero", 1, 8'h10, 8'h00, 4'd3, 1'b0, 1);
        run_one("bad_op", 0, 8'h22, 8'h33, 4'd9, 1'b1, 1);
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   lat;
        int   busy;
        rsp_t e;
        rsp_t snap;
        rsp_t got;
        rsp_ready = 1'b0;
        set_lane(0, 8'd5, 8'd5, 4'd1, 1'b0);
        set_lane(1, 8'd1, 8'd2, 4'd0, 1'b0);
        req_valid = 2'b01;
        sb.push_back(exp_of(1'b0, 8'd5, 8'd5, 4'd1, 1'b0));
        wait_grant(ok);
        @(posedge CLk);
        #1 req_valid = 2'b11;
        wait_rsp(lat, busy);
        checks++;
        if (lat != 3 || busy != 0) begin
            errors++;
            $display("FAIL bp_latency got lat=%0d grants=%0d want lat=3 grants=0", lat, busy);
        end
        e    = sb.pop_front();
        snap = '{id: rsp_id, res: rsp_result, cout: rsp_cout, z: rsp_zflag, err: rsp_err};
        checks++;
        if (snap !== e) begin
            errors++;
            $display("FAIL bp_rsp got res=%h c=%b z=%b e=%b want res=%h c=%b z=%b e=%b",
                     snap.res, snap.cout, snap.z, snap.err, e.res, e.cout, e.z, e.err);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge CLk);
            got = '{id: rsp_id, res: rsp_result, cout: rsp_cout, z: rsp_zflag, err: rsp_err};
            checks++;
            if (!rsp_valid || got !== e || req_ready !== 2'b00 || ops_done !== exp_ops) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got v=%b rsp=%h rdy=%b ops=%h want v=1 rsp=%h rdy=00 ops=%h",
                         k, rsp_valid, got, req_ready, ops_done, e, exp_ops);
            end
        end
        @(posedge CLk);
        #1;
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        @(posedge CLk);
        exp_ops = exp_ops + 16'd1;
        #1;
        checks++;
        if (ops_done !== exp_ops || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got ops=%h v=%b want ops=%h v=0", ops_done, rsp_valid, exp_ops);
        end
    endtask

    task automatic test_round_robin();
        bit   ok;
        int   lat;
        int   busy;
        rsp_t e;
        rsp_t got;
        logic want_win;
        do_reset();
        set_lane(0, 8'h11, 8'h22, 4'd0, 1'b0);
        set_lane(1, 8'hF0, 8'h3C, 4'd2, 1'b0);
        req_valid = 2'b11;
        want_win  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_grant(ok);
            checks++;
            if (!ok || req_ready !== (want_win ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_grant%0d got=%b want=%b", i, req_ready, want_win ? 2'b10 : 2'b01);
                break;
            end
            if (want_win) sb.push_back(exp_of(1'b1, 8'hF0, 8'h3C, 4'd2, 1'b0));
            else          sb.push_back(exp_of(1'b0, 8'h11, 8'h22, 4'd0, 1'b0));
            @(posedge CLk);
            #1;
            wait_rsp(lat, busy);
            if (lat < 0) begin
                checks++;
                errors++;
                $display("FAIL rr_timeout%0d got=none want=rsp_valid", i);
                break;
            end
            e   = sb.pop_front();
            got = '{id: rsp_id, res: rsp_result, cout: rsp_cout, z: rsp_zflag, err: rsp_err};
            checks++;
            if (got !== e || busy != 0) begin
                errors++;
                $display("FAIL rr_rsp%0d got rsp=%h grants=%0d want rsp=%h grants=0", i, got, busy, e);
            end
            @(posedge CLk);
            exp_ops  = exp_ops + 16'd1;
            want_win = ~want_win;
            #1;
        end
        req_valid = 2'b00;
        checks++;
        if (ops_done !== 16'd4) begin errors++; $display("FAIL rr_ops_done got=%h want=0004", ops_done); end
    endtask

    task automatic test_reset_in_capt();
        bit ok;
        int seen;
        do_reset();
        set_lane(0, 8'h01, 8'h01, 4'd0, 1'b0);
        req_valid = 2'b01;
        wait_grant(ok);
        @(posedge CLk);
        #1 req_valid = 2'b00;
        @(posedge CLk);
        #1 Reset = 1'b1;
        @(posedge CLk);
        #1 Reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLk);
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0 || ops_done !== 16'd0) begin
            errors++;
            $display("FAIL capt_reset got rsp_cycles=%0d ops=%h want rsp_cycles=0 ops=0000", seen, ops_done);
        end
        @(posedge CLk);
        #1;
        run_one("after_reset_add", 0, 8'h40, 8'h02, 4'd0, 1'b1, 3);
    endtask

    initial begin
        test_reset();
        test_add();
        test_ops();
        test_error();
        test_backpressure();
        test_round_robin();
        test_reset_in_capt();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 SHALL have ports: CLk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: req_valid  in  2  per-requester request valid, bit i = requester i.
REQ-004 SHALL have: req_ready  out  2  per-requester grant/accept.
REQ-005 SHALL have: req_a  in  16  operand A, lane i = bits [8i+7:8i].
REQ-006 SHALL have: req_b  in  16  operand B, same lane layout.
REQ-007 SHALL have: req_op  in  8  op code, lane i = bits [4i+3:4i].
REQ-008 SHALL have: req_cin  in  2  carry-in per requester.
REQ-009 SHALL have: alu_a, alu_b  out  8 each; alu_op  out  4; alu_cin  out  1  registered ALU operand drive.
REQ-010 SHALL have: alu_result  in  16; alu_cout  in  1; alu_zflag  in  1  registered ALU outputs, 1-cycle ALU latency.
REQ-011 SHALL have: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1  serving requester.
REQ-012 SHALL have: rsp_result  out  16; rsp_cout  out  1; rsp_zflag  out  1; rsp_err  out  1.
REQ-013 SHALL have: ops_done  out  16  count of responses accepted.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> CAPT -> RESP -> IDLE, plus IDLE -> RESP on error.
REQ-015 IDLE: req_ready SHALL be one-hot of the winner, combinational from req_valid; 00 in every other state.
REQ-016 Arbitration SHALL be round-robin: single valid wins; both valid -> requester other than last-served pointer wins.
REQ-017 Pointer SHALL update to the winner only on accept (valid & ready).
REQ-018 Accept with op in 0..5 and not (op==3 and B==0): latch alu_a/b/op/cin, rsp_id; go EXEC.
REQ-019 EXEC: one cycle, ALU registers result; go CAPT.
REQ-020 CAPT: latch rsp_result=alu_result, rsp_zflag=alu_zflag, rsp_err=0; go RESP.
REQ-021 rsp_cout SHALL equal alu_cout for op 0 only; forced 0 for ops 1..5.
REQ-022 Accept with op>5, or op==3 and B==0: alu_* unchanged; rsp_err=1, rsp_result=0, rsp_cout=0, rsp_zflag=1; go RESP next cycle.
REQ-023 Latency: accept in cycle N -> rsp_valid high from cycle N+3 (normal) or N+1 (error).
REQ-024 RESP: rsp_valid=1, all rsp_* held stable until rsp_ready=1; then IDLE next cycle.
REQ-025 Only one operation SHALL be in flight; no accept from response acceptance until IDLE is re-entered.
REQ-026 ops_done SHALL increment on each rsp_valid & rsp_ready, including errors; wrap 0xFFFF -> 0x0000.
REQ-027 req_valid deasserted by a losing requester SHALL be legal and SHALL not change the pointer.

Reset
REQ-028 Reset SHALL force IDLE; pointer=1 (requester 0 wins first tie).
REQ-029 Reset values: req_ready=00, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cout=0, rsp_zflag=0, rsp_err=0, alu_a=alu_b=0, alu_op=0, alu_cin=0, ops_done=0.
REQ-030 Reset in any state, including mid EXEC/CAPT/RESP, SHALL discard the in-flight operation; no response is issued.
REQ-031 Reset SHALL take priority over simultaneous accept or response handshake.

Verification
REQ-032 Req0 add A=0xFF B=0x01 cin=1, rsp_ready=1 -> rsp_valid at N+3, result=0x0101, cout=1, zflag=0, id=0, err=0.
REQ-033 Both valid every cycle, rsp_ready=1, after reset -> grants alternate 0,1,0,1; ops_done=4 after four responses.
REQ-034 Req1 op=3 A=0x10 B=0 -> rsp_valid at N+1, err=1, result=0, zflag=1; alu_* unchanged.
REQ-035 Req0 sub A=5 B=5, rsp_ready held 0 for 5 cycles -> rsp_* stable, result=0, zflag=1, cout=0; req_ready=00 throughout.
REQ-036 Reset asserted in CAPT -> next cycle IDLE, rsp_valid=0, ops_done unchanged at 0; following req0 accept proceeds normally.
